seg7_product_receiver: RTL and testbench
========================================

// Module: seg7_product_receiver
// PURPOSE
//  Receiving end of the time-multiplexed two-digit 7-segment display link driven by the
//  4-bit multiplier top. Filters glitches on {segments, digit-select}. Decodes each settled
//  pattern back to a hex nibble. Reassembles MSB then LSB into the 8-bit product.
//  Used on-chip as loopback checker and in the bench as display scoreboard.
// PARAMETERS
//  STABLE_CYCLES   4     cycles a symbol must be unchanged before capture (legal range 2..15)
//  TIMEOUT_CYCLES  2600  max cycles from MSB capture to LSB capture (>= 2 display phases)
// PORTS
//  clk           in   1  system clock (2500 Hz in product)
//  reset         in   1  synchronous, active-high reset
//  i_segments    in   7  {g,f,e,d,c,b,a}, 1 = segment lit
//  i_lsb_digit   in   1  digit select: 0 = MSB nibble shown, 1 = LSB nibble shown
//  o_value       out  8  last complete product {msb,lsb}; held until next frame
//  o_valid       out  1  one-cycle pulse: o_value updated this cycle
//  o_error       out  1  one-cycle pulse: illegal pattern or LSB timeout; frame dropped
//  o_busy        out  1  high while in S_HAVE_MSB
// BEHAVIOUR
//  - Reset: o_value=0, o_valid=0, o_error=0, o_busy=0, state S_HUNT, all counters 0,
//    sample register 0. Reset mid-frame discards any captured MSB.
//  - Symbol = {i_lsb_digit, i_segments}, registered every cycle.
//  - Stability counter: cleared when the new symbol != registered symbol. Otherwise it
//    increments and saturates.
//  - Settle event: fires exactly once per symbol occurrence. Occurs at the edge where the
//    symbol has been sampled on STABLE_CYCLES consecutive edges (first sample = edge k,
//    settle at edge k+STABLE_CYCLES-1). No second event until the symbol changes.
//  - Decode table (hex): 0=0111111 1=0000110 2=1011011 3=1001111 4=1100110 5=1101101
//    6=1111101 7=0000111 8=1111111 9=1101111 A=1110111 b=1111100 C=0111001 d=1011110
//    E=1111001 F=1110001. Any other pattern, including all-off, is illegal.
//  - FSM, evaluated on settle events only (timeout excepted):
//    S_HUNT:     settled legal MSB symbol -> latch nibble, clear timeout, go S_HAVE_MSB.
//                settled LSB symbol -> ignored (no MSB yet).
//                settled illegal pattern -> o_error pulse, stay in S_HUNT.
//    S_HAVE_MSB: settled legal LSB symbol -> o_value<={msb,lsb}, o_valid pulse at that
//                edge, go S_HUNT.
//                settled legal MSB symbol -> replace latched MSB, restart timeout, stay.
//                settled illegal pattern -> o_error pulse, go S_HUNT.
//                timeout counter reaches TIMEOUT_CYCLES -> o_error pulse, go S_HUNT.
//  - Simultaneous timeout and settle event: the settle event wins; no o_error from timeout.
//  - Timeout counter: $clog2(TIMEOUT_CYCLES+1) bits. Counts only in S_HAVE_MSB and never
//    wraps. Stability counter is 4 bits, saturating.
//  - o_valid and o_error never assert in the same cycle.
//  - Latency: o_valid rises STABLE_CYCLES-1 edges after the LSB symbol is first sampled.
//  - No CDC: inputs are synchronous to clk.
// STRUCTURE
//  - Shared package seg7_pkg: the 16 pattern localparams (SEG_0..SEG_F), shared with the
//    display encoder, and the FSM state encodings S_HUNT and S_HAVE_MSB.
//  - One sub-module, seg7_decode: combinational 7-bit pattern -> {legal, nibble[3:0]}.
//  - Top holds the sample register, stability counter, timeout counter, FSM and output
//    registers.
// TESTING
//  1. Reset, then MSB SEG_2 for 10 cycles, then LSB SEG_A for 10 cycles
//     -> o_valid pulse 3 edges after the LSB first sample; o_value=8'h2A; o_error=0.
//  2. MSB SEG_3 held; a 1-cycle glitch to SEG_8 mid-phase; then LSB SEG_1
//     -> one frame only, o_value=8'h31 (glitch shorter than STABLE_CYCLES is ignored).
//  3. Start with LSB SEG_5 after reset, then MSB SEG_0, then LSB SEG_9
//     -> first LSB ignored; single o_valid with o_value=8'h09.
//  4. MSB SEG_1 settled, then LSB pattern 7'b0000000
//     -> o_error pulse; o_value keeps its previous value; FSM back in S_HUNT.
//  5. MSB SEG_4 settled, no LSB for 2600 cycles
//     -> o_error pulse at the timeout cycle; o_busy drops.
//     Repeat with LSB settling on the exact timeout cycle -> o_valid only.
//  6. Assert reset while in S_HAVE_MSB, release, send LSB SEG_6
//     -> no o_valid; all outputs 0 after reset.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment patterns and receiver FSM state encodings
// Contents:
//   SEG_0..SEG_F  7-bit segment patterns {g,f,e,d,c,b,a}, 1 = lit (shared with the encoder)
//   state_t       receiver FSM states S_HUNT / S_HAVE_MSB
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1101111;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b1111100;
  localparam logic [6:0] SEG_C = 7'b0111001;
  localparam logic [6:0] SEG_D = 7'b1011110;
  localparam logic [6:0] SEG_E = 7'b1111001;
  localparam logic [6:0] SEG_F = 7'b1110001;

  typedef enum logic {
    S_HUNT     = 1'b0,
    S_HAVE_MSB = 1'b1
  } state_t;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational 7-segment pattern to hex nibble decoder
// Ports:
//   segments  in   7  {g,f,e,d,c,b,a}, 1 = segment lit
//   legal     out  1  pattern is one of the 16 hex glyphs
//   nibble    out  4  decoded value (0 when not legal)
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] segments,
  output logic       legal,
  output logic [3:0] nibble
);

  always_comb begin
    legal  = 1'b1;
    nibble = 4'h0;
    case (segments)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_product_receiver.sv
// rtl/seg7_product_receiver.sv - deglitching receiver for the two-digit muxed 7-segment product link
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   i_segments    7  {g,f,e,d,c,b,a}, 1 = lit
//   i_lsb_digit   1  0 = MSB nibble shown, 1 = LSB nibble shown
//   o_value       8  last complete product {msb,lsb}
//   o_valid       1  pulse: o_value updated
//   o_error       1  pulse: illegal pattern or LSB timeout, frame dropped
//   o_busy        1  MSB latched, waiting for LSB
module seg7_product_receiver
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 2600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] i_segments,
  input  logic       i_lsb_digit,
  output logic [7:0] o_value,
  output logic       o_valid,
  output logic       o_error,
  output logic       o_busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  // The counter holds (samples seen - 1), so the settling edge is the one
  // that moves it from STABLE_CYCLES-2 to STABLE_CYCLES-1.
  localparam logic [3:0]    SETTLE_CNT   = 4'(STABLE_CYCLES - 2);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_MAX  = TW'(TIMEOUT_CYCLES);

  logic [7:0]    sym_in, sym_q;
  logic [3:0]    stab_cnt;
  logic [TW-1:0] tcnt;
  state_t        state, state_next;
  logic [3:0]    msb_q, msb_next;
  logic [7:0]    value_next;
  logic          valid_next, error_next, tcnt_clear;
  logic          settle, timeout_hit, legal;
  logic [3:0]    nibble;

  assign sym_in = {i_lsb_digit, i_segments};

  seg7_decode u_decode (
    .segments (sym_in[6:0]),
    .legal    (legal),
    .nibble   (nibble)
  );

  assign settle      = (sym_in == sym_q) && (stab_cnt == SETTLE_CNT);
  assign timeout_hit = (state == S_HAVE_MSB) && (tcnt >= TIMEOUT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      sym_q    <= 8'h00;
      stab_cnt <= 4'd0;
      tcnt     <= '0;
      state    <= S_HUNT;
      msb_q    <= 4'h0;
      o_value  <= 8'h00;
      o_valid  <= 1'b0;
      o_error  <= 1'b0;
    end else begin
      sym_q <= sym_in;
      if (sym_in != sym_q)
        stab_cnt <= 4'd0;
      else if (stab_cnt != 4'hF)
        stab_cnt <= stab_cnt + 4'd1;
      if (tcnt_clear)
        tcnt <= '0;
      else if (state == S_HAVE_MSB && tcnt != TIMEOUT_MAX)
        tcnt <= tcnt + 1'b1;
      state   <= state_next;
      msb_q   <= msb_next;
      o_value <= value_next;
      o_valid <= valid_next;
      o_error <= error_next;
    end
  end

  // A settle event takes priority over a coincident timeout.
  always_comb begin
    state_next = state;
    msb_next   = msb_q;
    value_next = o_value;
    valid_next = 1'b0;
    error_next = 1'b0;
    tcnt_clear = 1'b0;
    if (settle) begin
      if (!legal) begin
        error_next = 1'b1;
        state_next = S_HUNT;
      end else if (!sym_in[7]) begin
        msb_next   = nibble;
        tcnt_clear = 1'b1;
        state_next = S_HAVE_MSB;
      end else if (state == S_HAVE_MSB) begin
        value_next = {msb_q, nibble};
        valid_next = 1'b1;
        state_next = S_HUNT;
      end
    end else if (timeout_hit) begin
      error_next = 1'b1;
      state_next = S_HUNT;
    end
  end

  assign o_busy = (state == S_HAVE_MSB);

endmodule

// File: tb/tb_seg7_product_receiver.sv
// tb/tb_seg7_product_receiver.sv - self-checking bench for seg7_product_receiver
module tb_seg7_product_receiver;

  localparam int S = 4;
  localparam int T = 2600;
  localparam logic [6:0] PAT [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110, 7'b1101101,
    7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] i_segments = 7'h00;
  logic       i_lsb_digit = 1'b0;
  logic [7:0] o_value;
  logic       o_valid, o_error, o_busy;

  int n_checks = 0;
  int n_fail = 0;

  seg7_product_receiver #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .i_segments(i_segments), .i_lsb_digit(i_lsb_digit),
    .o_value(o_value), .o_valid(o_valid), .o_error(o_error), .o_busy(o_busy));

  always #5 clk = ~clk;

  // Reference model: run length of identical samples, settle on the S-th one,
  // then frame assembly rules applied directly.
  logic [7:0] m_prev;
  int         m_run, m_age, m_msb;
  bit         m_have;
  logic [7:0] m_value;
  bit         m_valid, m_error;

  function automatic int lookup(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (PAT[i] == p) return i;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_prev = 8'h00; m_run = 1; m_have = 0; m_age = 0; m_msb = 0;
      m_value = 8'h00; m_valid = 0; m_error = 0;
    end else begin
      int nib;
      if ({i_lsb_digit, i_segments} == m_prev) m_run++;
      else m_run = 1;
      m_prev = {i_lsb_digit, i_segments};
      m_valid = 0; m_error = 0;
      if (m_have) m_age++;
      if (m_run == S) begin
        nib = lookup(i_segments);
        if (nib < 0) begin
          m_error = 1; m_have = 0;
        end else if (!i_lsb_digit) begin
          m_have = 1; m_msb = nib; m_age = 0;
        end else if (m_have) begin
          m_value = 8'((m_msb << 4) | nib); m_valid = 1; m_have = 0;
        end
      end else if (m_have && m_age >= T) begin
        m_error = 1; m_have = 0;
      end
    end
  end

  // Observation record, cleared at the start of each scenario.
  int n_val, n_err, val_at, err_at, edge_n, mism;

  task automatic clear_obs();
    n_val = 0; n_err = 0; val_at = 0; err_at = 0; edge_n = 0; mism = 0;
  endtask

  task automatic hold(input bit lsb, input logic [6:0] seg, input int n);
    for (int i = 0; i < n; i++) begin
      i_lsb_digit = lsb; i_segments = seg;
      @(posedge clk); @(negedge clk);
      edge_n++;
      if (o_valid === 1'b1) begin n_val++; if (val_at == 0) val_at = edge_n; end
      if (o_error === 1'b1) begin n_err++; if (err_at == 0) err_at = edge_n; end
      if (o_valid !== m_valid || o_error !== m_error || o_value !== m_value ||
          o_busy !== m_have)
        mism++;
    end
  endtask

  task automatic do_reset(input bit lsb, input logic [6:0] seg, input int n);
    reset = 1'b1; i_lsb_digit = lsb; i_segments = seg;
    repeat (n) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b0, PAT[2], 3);
    n_checks += 4;
    if (o_value !== 8'h00) begin n_fail++; $display("FAIL reset_value got %h want 00", o_value); end
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", o_valid); end
    if (o_error !== 1'b0) begin n_fail++; $display("FAIL reset_error got %b want 0", o_error); end
    if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", o_busy); end
  endtask

  task automatic test_basic_frame();
    clear_obs();
    hold(1'b0, PAT[2], 10);
    hold(1'b1, PAT[10], 10);
    n_checks += 5;
    if (n_val !== 1) begin n_fail++; $display("FAIL basic_nvalid got %0d want 1", n_val); end
    if (val_at !== 14) begin n_fail++; $display("FAIL basic_latency got edge %0d want 14", val_at); end
    if (o_value !== 8'h2A) begin n_fail++; $display("FAIL basic_value got %h want 2a", o_value); end
    if (n_err !== 0) begin n_fail++; $display("FAIL basic_error got %0d want 0", n_err); end
    if (mism !== 0) begin n_fail++; $display("FAIL basic_model got %0d mismatching cycles want 0", mism); end
  endtask

  task automatic test_glitch();
    do_reset(1'b0, PAT[3], 2);
    clear_obs();
    hold(1'b0, PAT[3], 5);
    hold(1'b0, PAT[8], 1);
    hold(1'b0, PAT[3], 5);
    hold(1'b1, PAT[1], 10);
    n_checks += 3;
    if (n_val !== 1) begin n_fail++; $display("FAIL glitch_nvalid got %0d want 1", n_val); end
    if (o_value !== 8'h31) begin n_fail++; $display("FAIL glitch_value got %h want 31", o_value); end
    if (n_err !== 0 || mism !== 0) begin n_fail++; $display("FAIL glitch_clean got err %0d mism %0d want 0 0", n_err, mism); end
  endtask

  task automatic test_lsb_first();
    do_reset(1'b1, PAT[5], 2);
    clear_obs();
    hold(1'b1, PAT[5], 10);
    hold(1'b0, PAT[0], 10);
    hold(1'b1, PAT[9], 10);
    n_checks += 3;
    if (n_val !== 1) begin n_fail++; $display("FAIL lsbfirst_nvalid got %0d want 1", n_val); end
    if (o_value !== 8'h09) begin n_fail++; $display("FAIL lsbfirst_value got %h want 09", o_value); end
    if (n_err !== 0 || mism !== 0) begin n_fail++; $display("FAIL lsbfirst_clean got err %0d mism %0d want 0 0", n_err, mism); end
  endtask

  task automatic test_illegal();
    clear_obs();
    hold(1'b0, PAT[1], 10);
    hold(1'b1, 7'b0000000, 10);
    n_checks += 5;
    if (n_err !== 1) begin n_fail++; $display("FAIL illegal_nerror got %0d want 1", n_err); end
    if (n_val !== 0) begin n_fail++; $display("FAIL illegal_nvalid got %0d want 0", n_val); end
    if (o_value !== 8'h09) begin n_fail++; $display("FAIL illegal_value got %h want 09", o_value); end
    if (o_busy !== 1'b0) begin n_fail++; $display("FAIL illegal_busy got %b want 0", o_busy); end
    if (mism !== 0) begin n_fail++; $display("FAIL illegal_model got %0d want 0", mism); end
  endtask

  task automatic test_timeout();
    do_reset(1'b0, PAT[4], 2);
    clear_obs();
    hold(1'b0, PAT[4], 2610);
    n_checks += 4;
    if (n_err !== 1) begin n_fail++; $display("FAIL timeout_nerror got %0d want 1", n_err); end
    if (err_at !== 4 + T) begin n_fail++; $display("FAIL timeout_edge got %0d want %0d", err_at, 4 + T); end
    if (o_busy !== 1'b0 || n_val !== 0) begin n_fail++; $display("FAIL timeout_state got busy %b nvalid %0d want 0 0", o_busy, n_val); end
    if (mism !== 0) begin n_fail++; $display("FAIL timeout_model got %0d want 0", mism); end
    // LSB settles on the very edge the timeout would fire.
    do_reset(1'b0, PAT[4], 2);
    clear_obs();
    hold(1'b0, PAT[4], T);
    hold(1'b1, PAT[7], 10);
    n_checks += 3;
    if (n_val !== 1 || val_at !== 4 + T) begin n_fail++; $display("FAIL tie_valid got n %0d at %0d want 1 at %0d", n_val, val_at, 4 + T); end
    if (n_err !== 0) begin n_fail++; $display("FAIL tie_error got %0d want 0", n_err); end
    if (o_value !== 8'h47) begin n_fail++; $display("FAIL tie_value got %h want 47", o_value); end
    // One cycle later the timeout wins.
    do_reset(1'b0, PAT[4], 2);
    clear_obs();
    hold(1'b0, PAT[4], T + 1);
    hold(1'b1, PAT[7], 10);
    n_checks += 2;
    if (n_err !== 1 || err_at !== 4 + T) begin n_fail++; $display("FAIL late_error got n %0d at %0d want 1 at %0d", n_err, err_at, 4 + T); end
    if (n_val !== 0) begin n_fail++; $display("FAIL late_valid got %0d want 0", n_val); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset(1'b0, PAT[5], 2);
    clear_obs();
    hold(1'b0, PAT[5], 10);
    n_checks += 1;
    if (o_busy !== 1'b1) begin n_fail++; $display("FAIL midreset_busy_before got %b want 1", o_busy); end
    do_reset(1'b1, PAT[6], 2);
    n_checks += 1;
    if ({o_value, o_valid, o_error, o_busy} !== 11'h0) begin n_fail++; $display("FAIL midreset_outputs got %h want 000", {o_value, o_valid, o_error, o_busy}); end
    clear_obs();
    hold(1'b1, PAT[6], 10);
    n_checks += 2;
    if (n_val !== 0 || n_err !== 0) begin n_fail++; $display("FAIL midreset_pulses got valid %0d error %0d want 0 0", n_val, n_err); end
    if (o_value !== 8'h00) begin n_fail++; $display("FAIL midreset_value got %h want 00", o_value); end
  endtask

  task automatic test_random();
    int model_val = 0;
    do_reset(1'b0, PAT[0], 2);
    clear_obs();
    for (int k = 0; k < 400; k++) begin
      logic [6:0] seg;
      int r = int'($urandom_range(0, 9));
      seg = (r == 0) ? 7'($urandom) : PAT[$urandom_range(0, 15)];
      hold(1'($urandom), seg, int'($urandom_range(1, 8)));
      if (m_valid) model_val++;
    end
    n_checks += 2;
    if (mism !== 0) begin n_fail++; $display("FAIL random_model got %0d mismatching cycles want 0", mism); end
    if (n_val < model_val) begin n_fail++; $display("FAIL random_nvalid got %0d want at least %0d", n_val, model_val); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_glitch();
    test_lsb_first();
    test_illegal();
    test_timeout();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
